mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Consumer of the EX/MEM issue A/B buffers. Performs issue-A loads/stores over a req/ack data-memory bus and stalls the pipe while waiting.
//  Registers the MEM/WB buffers for both issues and supplies the A_FWD_MEM/B_FWD_MEM and A_FWD_WB/B_FWD_WB forwarding values.
//  Only issue A touches memory; issue B passes ALU results through.
// PARAMETERS
//  MAX_WAIT   15   cycles in WAIT before a bus-timeout abort (1..255)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  ia_alu_out     in  32   issue A ALU result / effective address
//  ia_rs2_data    in  32   issue A store data
//  ia_rd_addr     in   5   issue A destination
//  ia_reg_write   in   1   issue A writes rd
//  ia_mem_write   in   1   issue A is a store
//  ia_mem_read    in   1   issue A is a load
//  ia_funct3      in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ib_alu_out     in  32   issue B ALU result
//  ib_rd_addr     in   5   issue B destination
//  ib_reg_write   in   1   issue B writes rd
//  dmem_req       out  1   request valid
//  dmem_we        out  1   1 = write
//  dmem_addr      out 32   word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata     out 32   store data, lane-shifted
//  dmem_be        out  4   byte enables
//  dmem_ack       in   1   request done; rdata valid this cycle for reads
//  dmem_rdata     in  32   read data word
//  mem_stall      out  1   hold IF..EX and the EX/MEM buffers
//  a_fwd_mem_data out 32   = ia_alu_out (comb)
//  b_fwd_mem_data out 32   = ib_alu_out (comb)
//  oa_wb_data     out 32   MEM/WB A result (also A_FWD_WB)
//  oa_rd_addr     out  5   MEM/WB A destination
//  oa_reg_write   out  1   MEM/WB A write enable
//  ob_wb_data     out 32   MEM/WB B result (also B_FWD_WB)
//  ob_rd_addr     out  5   MEM/WB B destination
//  ob_reg_write   out  1   MEM/WB B write enable
//  o_bus_err      out  1   1-cycle pulse: timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//  - mem_op = ia_mem_read | ia_mem_write. FSM IDLE/WAIT; counter wait_cnt[7:0].
//  - dmem_req = mem_op in IDLE, or state==WAIT. dmem_we = ia_mem_write. Address/data/be are comb from ia_* (held stable by the stall).
//  - mem_stall = dmem_req & ~dmem_ack & ~timeout.
//  - IDLE: mem_op & ~ack -> WAIT, wait_cnt = 1. mem_op & ack -> stay IDLE; result captured that edge (zero-wait memory, no stall).
//  - WAIT: ack -> IDLE, capture. wait_cnt == MAX_WAIT & ~ack -> timeout: IDLE, o_bus_err = 1, oa/ob_reg_write = 0, stall released. Otherwise wait_cnt++.
//  - MEM/WB capture on every edge with ~mem_stall:
//      oa_wb_data = load ? ext(rdata) : ia_alu_out;
//      oa_reg_write = ia_reg_write; B mirrors with ib_*.
//    While mem_stall, a bubble is written: oa/ob_reg_write = 0; rd and data hold.
//  - Load extract: lane = addr[1:0]. B/BU take byte lane; H/HU take half addr[1]. Sign/zero-extend to 32.
//  - Store: SB be = 0001<<lane, wdata = {4{b}}; SH be = 0011<<(2*addr[1]), wdata = {2{h}}; SW be = 1111.
//  - Reset: all outputs 0, FSM IDLE, wait_cnt 0; reset in WAIT drops dmem_req the next cycle, and the access is abandoned.
//  - Simultaneous ack and wait_cnt == MAX_WAIT: ack wins, no error.
// CONFIGURATION
//  - MEM_MISALIGN_EXC_EN defined: misaligned H/W access (H with addr[0], W with addr[1:0] != 0) issues no dmem_req.
//    It gives a 1-cycle o_bus_err, oa_reg_write = 0, no stall.
//  - Not defined: the access proceeds with the low address bits used only for lane select (W ignores them); o_bus_err is timeout-only.
// STRUCTURE
//  - Shared defines header: funct3 size codes, FSM state encodings, BE patterns.
//  - Sub-module load_store_align (comb): wdata/be generation and load extract/extension.
// TESTING
//  - LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next cycle oa_wb_data = 0xDEADBEEF, oa_reg_write = 1.
//  - LB addr 0x103, rdata 0x80xxxxxx, ack after 3 cycles -> mem_stall 3 cycles, 3 bubbles, then oa_wb_data = 0xFFFFFF80.
//    LBU with the same inputs -> 0x00000080.
//  - SH addr 0x202, data 0x1234 -> dmem_be = 1100, dmem_wdata = 0x12341234, dmem_we = 1, oa_reg_write = 0.
//  - No ack, MAX_WAIT = 15 -> stall cycles 1..15, o_bus_err pulse on cycle 16, both reg_writes 0.
//    Ack arriving exactly at wait_cnt == 15 -> no error.
//  - rst asserted in WAIT -> next cycle dmem_req = 0, all outputs 0.
//    Issue-B-only traffic -> ob_wb_data = ib_alu_out one cycle later, never stalls.
//  - MEM_MISALIGN_EXC_EN: LW addr 0x101 -> no dmem_req, o_bus_err = 1; without the macro, dmem_addr = 0x100, normal load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 size codes, FSM states, byte-enable patterns.
// Also holds the alignment predicate used when misaligned accesses are trapped.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering: store data replication / byte enables, load extract and extension.
// Low address bits only pick lanes; word accesses ignore them.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_wdata = i_store_data;
    o_be    = BE_W;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_be    = BE_B << i_lane;
      end
      2'b01: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_be    = BE_H << {i_lane[1], 1'b0};
      end
      default: begin
        o_wdata = i_store_data;
        o_be    = BE_W;
      end
    endcase
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issue-A loads/stores over a req/ack bus with stall and timeout, MEM/WB registers for A and B.
// Define MEM_MISALIGN_EXC_EN to trap misaligned H/W accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ia_alu_out,
  input  logic [31:0] ia_rs2_data,
  input  logic [4:0]  ia_rd_addr,
  input  logic        ia_reg_write,
  input  logic        ia_mem_write,
  input  logic        ia_mem_read,
  input  logic [2:0]  ia_funct3,
  input  logic [31:0] ib_alu_out,
  input  logic [4:0]  ib_rd_addr,
  input  logic        ib_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] a_fwd_mem_data,
  output logic [31:0] b_fwd_mem_data,
  output logic [31:0] oa_wb_data,
  output logic [4:0]  oa_rd_addr,
  output logic        oa_reg_write,
  output logic [31:0] ob_wb_data,
  output logic [4:0]  ob_rd_addr,
  output logic        ob_reg_write,
  output logic        o_bus_err
);

  state_e      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_bus_err;

  logic        w_mem_op;
  logic        w_mis_err;
  logic        w_acc;
  logic        w_timeout;
  logic [31:0] w_load_data;

  load_store_align u_align (
    .i_lane       (ia_alu_out[1:0]),
    .i_funct3     (ia_funct3),
    .i_store_data (ia_rs2_data),
    .i_rdata      (dmem_rdata),
    .o_wdata      (dmem_wdata),
    .o_be         (dmem_be),
    .o_load_data  (w_load_data)
  );

  assign w_mem_op = ia_mem_read | ia_mem_write;
`ifdef MEM_MISALIGN_EXC_EN
  assign w_mis_err = w_mem_op & is_misaligned(ia_funct3, ia_alu_out[1:0]);
`else
  assign w_mis_err = 1'b0;
`endif
  assign w_acc     = w_mem_op & ~w_mis_err;
  assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == 8'(MAX_WAIT)) && !dmem_ack;

  assign dmem_req       = (r_state == ST_IDLE) ? w_acc : 1'b1;
  assign dmem_we        = ia_mem_write;
  assign dmem_addr      = {ia_alu_out[31:2], 2'b00};
  assign mem_stall      = dmem_req & ~dmem_ack & ~w_timeout;
  assign a_fwd_mem_data = ia_alu_out;
  assign b_fwd_mem_data = ib_alu_out;
  assign o_bus_err      = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && !dmem_ack) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 8'd1;
          end
          if (w_mis_err) r_bus_err <= 1'b1;
        end
        default: begin
          if (dmem_ack) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // A stalled edge writes a bubble: enables drop, destination and data keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      oa_wb_data   <= 32'd0;
      oa_rd_addr   <= 5'd0;
      oa_reg_write <= 1'b0;
      ob_wb_data   <= 32'd0;
      ob_rd_addr   <= 5'd0;
      ob_reg_write <= 1'b0;
    end else if (mem_stall) begin
      oa_reg_write <= 1'b0;
      ob_reg_write <= 1'b0;
    end else begin
      oa_wb_data   <= ia_mem_read ? w_load_data : ia_alu_out;
      oa_rd_addr   <= ia_rd_addr;
      oa_reg_write <= ia_reg_write & ~w_timeout & ~w_mis_err;
      ob_wb_data   <= ib_alu_out;
      ob_rd_addr   <= ib_rd_addr;
      ob_reg_write <= ib_reg_write & ~w_timeout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected MEM/WB results, bench-side memory responder.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ia_alu_out, ia_rs2_data, ib_alu_out;
  logic [4:0]  ia_rd_addr, ib_rd_addr;
  logic        ia_reg_write, ia_mem_write, ia_mem_read, ib_reg_write;
  logic [2:0]  ia_funct3;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] a_fwd_mem_data, b_fwd_mem_data, oa_wb_data, ob_wb_data;
  logic [4:0]  oa_rd_addr, ob_rd_addr;
  logic        oa_reg_write, ob_reg_write, o_bus_err;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .ia_alu_out(ia_alu_out), .ia_rs2_data(ia_rs2_data), .ia_rd_addr(ia_rd_addr),
    .ia_reg_write(ia_reg_write), .ia_mem_write(ia_mem_write), .ia_mem_read(ia_mem_read),
    .ia_funct3(ia_funct3), .ib_alu_out(ib_alu_out), .ib_rd_addr(ib_rd_addr),
    .ib_reg_write(ib_reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .a_fwd_mem_data(a_fwd_mem_data), .b_fwd_mem_data(b_fwd_mem_data),
    .oa_wb_data(oa_wb_data), .oa_rd_addr(oa_rd_addr), .oa_reg_write(oa_reg_write),
    .ob_wb_data(ob_wb_data), .ob_rd_addr(ob_rd_addr), .ob_reg_write(ob_reg_write),
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ad;
    logic [4:0]  ard;
    logic        aw;
    logic [31:0] bd;
    logic [4:0]  brd;
    logic        bw;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  int          s_stalls;

  task automatic idle();
    ia_alu_out = 0; ia_rs2_data = 0; ia_rd_addr = 0; ia_reg_write = 0;
    ia_mem_write = 0; ia_mem_read = 0; ia_funct3 = 3'b010;
    ib_alu_out = 0; ib_rd_addr = 0; ib_reg_write = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // One issue slot; ack_lat < 0 means the memory never answers.
  task automatic run_op(input string name, input logic [31:0] a_alu, input logic [31:0] a_rs2,
                        input logic [2:0] f3, input logic a_rw, input logic a_ld, input logic a_st,
                        input logic [31:0] b_alu, input logic b_rw, input int ack_lat,
                        input logic [31:0] rdata, input logic [31:0] exp_ad, input logic exp_aw,
                        input logic exp_bw, input logic exp_err, input int exp_stalls);
    exp_t e, got;
    int   cyc;
    bit   done;
    cyc = 0; done = 0; s_stalls = 0;
    ia_alu_out = a_alu; ia_rs2_data = a_rs2; ia_rd_addr = 5'd3; ia_reg_write = a_rw;
    ia_mem_write = a_st; ia_mem_read = a_ld; ia_funct3 = f3;
    ib_alu_out = b_alu; ib_rd_addr = 5'd7; ib_reg_write = b_rw; dmem_rdata = rdata;
    while (!done && cyc < 300) begin
      dmem_ack = (cyc == ack_lat);
      @(negedge clk);
      if (cyc == 0) begin
        s_req = dmem_req; s_we = dmem_we; s_addr = dmem_addr; s_wdata = dmem_wdata; s_be = dmem_be;
      end
      if (mem_stall) begin
        s_stalls++;
        @(posedge clk); #1;
        checks++;
        if (oa_reg_write !== 1'b0 || ob_reg_write !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble cyc%0d: reg_write a=%b b=%b, required 0 0", name, cyc, oa_reg_write, ob_reg_write);
        end
        cyc++;
      end else begin
        e.ad = exp_ad; e.ard = 5'd3; e.aw = exp_aw; e.bd = b_alu; e.brd = 5'd7; e.bw = exp_bw; e.err = exp_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        done = 1;
      end
    end
    idle();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s hang: still stalled after %0d cycles", name, cyc);
      return;
    end
    got = sb_q.pop_front();
    checks++;
    if (s_stalls !== exp_stalls) begin
      errors++; $display("FAIL %s stalls: got %0d, required %0d", name, s_stalls, exp_stalls);
    end
    if (!got.err) begin
      checks++;
      if (oa_wb_data !== got.ad || oa_rd_addr !== got.ard) begin
        errors++; $display("FAIL %s a_data: got %h rd %0d, required %h rd %0d", name, oa_wb_data, oa_rd_addr, got.ad, got.ard);
      end
    end
    checks++;
    if (oa_reg_write !== got.aw || ob_reg_write !== got.bw) begin
      errors++; $display("FAIL %s reg_write: got a=%b b=%b, required a=%b b=%b", name, oa_reg_write, ob_reg_write, got.aw, got.bw);
    end
    checks++;
    if (ob_wb_data !== got.bd || ob_rd_addr !== got.brd) begin
      errors++; $display("FAIL %s b_data: got %h rd %0d, required %h rd %0d", name, ob_wb_data, ob_rd_addr, got.bd, got.brd);
    end
    checks++;
    if (o_bus_err !== got.err) begin
      errors++; $display("FAIL %s bus_err: got %b, required %b", name, o_bus_err, got.err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (dmem_req !== 0 || mem_stall !== 0 || oa_wb_data !== 0 || oa_reg_write !== 0 ||
        ob_wb_data !== 0 || ob_reg_write !== 0 || o_bus_err !== 0) begin
      errors++;
      $display("FAIL reset: req=%b stall=%b oa=%h/%b ob=%h/%b err=%b, required all 0",
               dmem_req, mem_stall, oa_wb_data, oa_reg_write, ob_wb_data, ob_reg_write, o_bus_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    run_op("lw_zero_wait", 32'h100, 0, 3'b010, 1, 1, 0, 32'h11, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 0);
    checks++;
    if (s_req !== 1'b1 || s_we !== 1'b0 || s_addr !== 32'h100) begin
      errors++; $display("FAIL lw_bus: req=%b we=%b addr=%h, required 1 0 00000100", s_req, s_we, s_addr);
    end
    run_op("lb_wait3", 32'h103, 0, 3'b000, 1, 1, 0, 32'h22, 1, 3, 32'h80123456, 32'hFFFFFF80, 1, 1, 0, 3);
    run_op("lbu_wait3", 32'h103, 0, 3'b100, 1, 1, 0, 32'h33, 1, 3, 32'h80123456, 32'h00000080, 1, 1, 0, 3);
    run_op("lh_hi", 32'h302, 0, 3'b001, 1, 1, 0, 32'h44, 0, 1, 32'h8001BEEF, 32'hFFFF8001, 1, 0, 0, 1);
    run_op("lhu_lo", 32'h300, 0, 3'b101, 1, 1, 0, 32'h55, 1, 2, 32'h1234F00D, 32'h0000F00D, 1, 1, 0, 2);
  endtask

  task automatic test_stores();
    run_op("sh", 32'h202, 32'h00001234, 3'b001, 0, 0, 1, 32'h66, 1, 0, 0, 32'h202, 0, 1, 0, 0);
    checks++;
    if (s_be !== 4'b1100 || s_wdata !== 32'h12341234 || s_we !== 1'b1 || s_addr !== 32'h200) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h we=%b addr=%h, required 1100 12341234 1 00000200", s_be, s_wdata, s_we, s_addr);
    end
    run_op("sb", 32'h201, 32'h000000AB, 3'b000, 0, 0, 1, 32'h77, 1, 2, 0, 32'h201, 0, 1, 0, 2);
    checks++;
    if (s_be !== 4'b0010 || s_wdata !== 32'hABABABAB) begin
      errors++; $display("FAIL sb_bus: be=%b wdata=%h, required 0010 abababab", s_be, s_wdata);
    end
    run_op("sw", 32'h208, 32'hCAFEBABE, 3'b010, 0, 0, 1, 32'h88, 0, 0, 0, 32'h208, 0, 0, 0, 0);
    checks++;
    if (s_be !== 4'b1111 || s_wdata !== 32'hCAFEBABE) begin
      errors++; $display("FAIL sw_bus: be=%b wdata=%h, required 1111 cafebabe", s_be, s_wdata);
    end
  endtask

  task automatic test_timeout();
    run_op("timeout", 32'h400, 0, 3'b010, 1, 1, 0, 32'h99, 1, -1, 0, 0, 0, 0, 1, 15);
    @(posedge clk); #1;
    checks++;
    if (o_bus_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: o_bus_err=%b one cycle later, required 0", o_bus_err);
    end
    run_op("ack_at_max", 32'h404, 0, 3'b010, 1, 1, 0, 32'hAA, 1, 15, 32'h0BADF00D, 32'h0BADF00D, 1, 1, 0, 15);
  endtask

  task automatic test_reset_in_wait();
    ia_alu_out = 32'h500; ia_rd_addr = 5'd9; ia_reg_write = 1; ia_mem_read = 1; ia_funct3 = 3'b010;
    dmem_ack = 0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre: mem_stall=%b, required 1", mem_stall);
    end
    rst = 1; idle();
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 0 || mem_stall !== 0 || oa_wb_data !== 0 || oa_rd_addr !== 0 || oa_reg_write !== 0 ||
        ob_wb_data !== 0 || ob_reg_write !== 0 || o_bus_err !== 0) begin
      errors++;
      $display("FAIL rst_wait: req=%b stall=%b oa=%h/%0d/%b ob=%h/%b err=%b, required all 0",
               dmem_req, mem_stall, oa_wb_data, oa_rd_addr, oa_reg_write, ob_wb_data, ob_reg_write, o_bus_err);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_b();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom;
      run_op("b_only", 32'h1000 + i, 0, 3'b010, 1, 0, 0, v, 1, -1, 0, 32'h1000 + i, 1, 1, 0, 0);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_EXC_EN
    run_op("lw_misalign", 32'h101, 0, 3'b010, 1, 1, 0, 32'hBB, 1, -1, 0, 0, 0, 1, 1, 0);
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL misalign_req: dmem_req=%b, required 0", s_req);
    end
`else
    run_op("lw_misalign", 32'h101, 0, 3'b010, 1, 1, 0, 32'hBB, 1, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 0, 0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      errors++; $display("FAIL misalign_addr: req=%b addr=%h, required 1 00000100", s_req, s_addr);
    end
`endif
  endtask

  initial begin
    rst = 1; idle();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_loads();
    test_stores();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back_b();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
